// File: rtl/swap_reg_unit.sv
// swap_reg_unit: two-register datapath (load/copy/swap/clear) behind a 3-cycle command handshake,
// with a free-running cycle counter and the timestamp of the last register change.
module swap_reg_unit #(
    parameter int WIDTH = 4,
    parameter int TW    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    output logic [WIDTH-1:0] reg_a,
    output logic [WIDTH-1:0] reg_b,
    output logic [TW-1:0]    t_now,
    output logic [TW-1:0]    t_last,
    output logic             done,
    output logic             changed
);
    typedef enum logic [1:0] {IDLE, EXEC, REPORT} state_t;
    state_t           r_state, w_next;
    logic [2:0]       r_op;
    logic [WIDTH-1:0] r_data, w_a, w_b;
    logic             w_chg;

    assign cmd_ready = (r_state == IDLE);

    // every destination is computed from pre-edge A/B
    always_comb begin
        w_next = r_state;
        w_a    = reg_a;
        w_b    = reg_b;
        case (r_state)
            IDLE:    w_next = cmd_valid ? EXEC : IDLE;
            EXEC:    w_next = REPORT;
            default: w_next = IDLE;
        endcase
        case (r_op)
            3'b001:  w_a = r_data;
            3'b010:  w_b = r_data;
            3'b011:  begin w_a = reg_b;  w_b = reg_a; end
            3'b100:  w_b = reg_a;
            3'b101:  w_a = reg_b;
            3'b110:  begin w_a = r_data; w_b = reg_a; end
            3'b111:  begin w_a = '0;     w_b = '0;    end
            default: ;
        endcase
        w_chg = (w_a != reg_a) || (w_b != reg_b);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_op    <= '0;
            r_data  <= '0;
            reg_a   <= '0;
            reg_b   <= '0;
            t_now   <= '0;
            t_last  <= '0;
            done    <= 1'b0;
            changed <= 1'b0;
        end else begin
            t_now   <= t_now + 1'b1;
            r_state <= w_next;
            if (cmd_ready && cmd_valid) begin
                r_op   <= cmd_op;
                r_data <= cmd_data;
            end
            if (r_state == EXEC) begin
                reg_a   <= w_a;
                reg_b   <= w_b;
                done    <= 1'b1;
                changed <= w_chg;
                if (w_chg)
                    t_last <= t_now;
            end else begin
                done    <= 1'b0;
                changed <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_swap_reg_unit.sv
// tb_swap_reg_unit: timestamp-based reference model checked every cycle, directed scenarios,
// randomized commands, and a TW=4 instance for counter wrap.
module tb_swap_reg_unit;
    logic        clk = 0, rst = 1;
    logic        cmd_valid = 0, cmd_ready;
    logic [2:0]  cmd_op = 0;
    logic [3:0]  cmd_data = 0, reg_a, reg_b;
    logic [15:0] t_now, t_last;
    logic        done, changed;

    logic        cmd_valid2 = 0, cmd_ready2, done2, changed2;
    logic [3:0]  reg_a2, reg_b2, t_now2, t_last2;

    int n_chk = 0, n_fail = 0;

    always #5 clk = ~clk;

    swap_reg_unit #(.WIDTH(4), .TW(16)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_data(cmd_data), .reg_a(reg_a), .reg_b(reg_b),
        .t_now(t_now), .t_last(t_last), .done(done), .changed(changed));

    swap_reg_unit #(.WIDTH(4), .TW(4)) dut4 (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid2), .cmd_ready(cmd_ready2),
        .cmd_op(3'b001), .cmd_data(4'hB), .reg_a(reg_a2), .reg_b(reg_b2),
        .t_now(t_now2), .t_last(t_last2), .done(done2), .changed(changed2));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // the opcode table: returns {A_new, B_new}
    function automatic logic [7:0] f(input logic [2:0] op, input logic [3:0] d, a, b);
        case (op)
            3'd1: f = {d, b};
            3'd2: f = {a, d};
            3'd3: f = {b, a};
            3'd4: f = {a, a};
            3'd5: f = {b, b};
            3'd6: f = {d, a};
            3'd7: f = 8'h00;
            default: f = {a, b};
        endcase
    endfunction

    // e = edges since reset, acc = edge index of the last acceptance
    int          e, acc;
    logic [3:0]  ma, mb, md;
    logic [2:0]  mop;
    logic [15:0] mlast;
    logic        mchg;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            e <= 0; acc <= -10; ma <= 0; mb <= 0; mlast <= 0; mchg <= 0; mop <= 0; md <= 0;
        end else begin
            e <= e + 1;
            if (e == acc) begin
                {ma, mb} <= f(mop, md, ma, mb);
                mchg     <= f(mop, md, ma, mb) != {ma, mb};
                if (f(mop, md, ma, mb) != {ma, mb}) mlast <= e[15:0];
            end
            if (e - acc >= 2 && cmd_valid) begin
                acc <= e + 1;
                mop <= cmd_op;
                md  <= cmd_data;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("reg_a", reg_a, ma);
            chk("reg_b", reg_b, mb);
            chk("t_now", t_now, e[15:0]);
            chk("t_last", t_last, mlast);
            chk("done", done, e - acc == 1);
            chk("changed", changed, (e - acc == 1) && mchg);
            chk("cmd_ready", cmd_ready, e - acc >= 2);
        end
    end

    task automatic issue(input logic [2:0] op, input logic [3:0] d);
        int k = 0;
        while (!cmd_ready && k < 20) begin @(negedge clk); k++; end
        chk("ready_timeout", cmd_ready, 1);
        cmd_valid = 1; cmd_op = op; cmd_data = d;
        @(negedge clk);
        cmd_valid = 0;
        @(negedge clk);
    endtask

    initial begin
        int dn;
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int dn;
        #12 rst = 0;
        repeat (5) @(negedge clk);
        chk("t_now_after5", t_now, 5);
        chk("t_last_idle", t_last, 0);
        #2 rst = 1;
        #1;
        chk("async_rst_zero", {reg_a, reg_b, t_now, t_last, done, changed}, 0);
        chk("async_rst_ready", cmd_ready, 1);
        @(negedge clk) rst = 0;

        issue(3'd1, 4'd5);
        chk("load_a_chg", changed, 1);
        issue(3'd2, 4'd3);
        chk("load_b_chg", changed, 1);
        issue(3'd3, 4'd0);
        chk("swap_a", reg_a, 3);
        chk("swap_b", reg_b, 5);
        chk("swap_chg", changed, 1);
        issue(3'd3, 4'd0);
        issue(3'd6, 4'd10);
        chk("shift1_a", reg_a, 10);
        chk("shift1_b", reg_b, 5);
        issue(3'd6, 4'd10);
        chk("shift2_b", reg_b, 10);
        chk("shift2_chg", changed, 1);
        issue(3'd3, 4'd0);
        chk("swap_same_done", done, 1);
        chk("swap_same_chg", changed, 0);

        @(negedge clk);
        dn = 0;
        cmd_valid = 1; cmd_op = 3'd1;
        for (int i = 0; i < 12; i++) begin
            cmd_data = 4'(i);
            @(negedge clk);
            dn += done;
        end
        cmd_valid = 0;
        repeat (3) begin @(negedge clk); dn += done; end
        chk("hold_done_count", dn, 4);

        issue(3'd1, 4'd7);
        issue(3'd2, 4'd9);
        @(negedge clk);
        cmd_valid = 1; cmd_op = 3'd7;
        @(negedge clk);
        cmd_valid = 0;
        #2 rst = 1;
        #1;
        chk("rst_exec_a", reg_a, 0);
        chk("rst_exec_b", reg_b, 0);
        cmd_valid = 1; cmd_op = 3'd1; cmd_data = 4'd4;
        @(negedge clk) rst = 0;
        @(negedge clk);
        chk("accept_after_rst", cmd_ready, 0);
        cmd_valid = 0;
        @(negedge clk);
        chk("accept_after_rst_a", reg_a, 4);

        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            cmd_valid = 1'($urandom_range(0, 1));
            cmd_op    = 3'($urandom_range(0, 7));
            cmd_data  = 4'($urandom_range(0, 15));
        end
        cmd_valid = 0;

        @(negedge clk);
        #2 rst = 1;
        @(negedge clk) rst = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            chk("tw4_t_now", t_now2, k % 16);
            cmd_valid2 = (k == 14);
            if (k == 16) begin
                chk("tw4_t_last", t_last2, 15);
                chk("tw4_reg_a", reg_a2, 4'hB);
                chk("tw4_done", done2, 1);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
